// File: rtl/pipeline_cmd_ctrl.sv
// pipeline_cmd_ctrl
//   Byte-stream command decoder for a set of N_PIPES processing pipelines. A command byte
//   (opcode in [7:4], pipe index in [3:0]) is followed by zero or more MSB-first operand
//   bytes. Once a command is complete, one single-cycle strobe is issued at the one-hot bit
//   of the target pipe. SWAP changes the active pipe and full-resets the previous one.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   in_byte/valid/ready byte stream in; a byte is taken when in_valid && in_ready
//   block_target        low bits of the block operand byte
//   reg_target          low REG_AW bits of the register operand byte
//   data_out            data operand (DATA_W bits)
//   instr_out           instruction operand (INSTR_W bits)
//   delay_out           delay operand (32 bits)
//   target_pipe         pipe index of the current command
//   instr_write, reg_write, reg_commit, alloc_delay, pipe_reset, pipe_full_reset
//                       one-hot per-pipe strobes
//   regfile_syncing     per-pipe "register file busy", stalls WRITE_REG
//   pipe_resetting      per-pipe "reset in progress", holds RESET_WAIT
//   swap_req, swap_busy swap handshake
//   active_pipe         currently active pipe
//   set_in_gain, set_out_gain  gain update strobes (value on data_out)
//   err_invalid         bad opcode / pipe index / swap to the active pipe
//   err_timeout         operand byte did not arrive within TIMEOUT cycles
//   busy, state         status (state encoding 0..9)
module pipeline_cmd_ctrl #(
    parameter int unsigned N_PIPES  = 2,
    parameter int unsigned N_BLOCKS = 32,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned REG_AW   = 4,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  in_byte,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [$clog2(N_BLOCKS)-1:0] block_target,
    output logic [REG_AW-1:0]           reg_target,
    output logic [DATA_W-1:0]           data_out,
    output logic [INSTR_W-1:0]          instr_out,
    output logic [31:0]                 delay_out,
    output logic [$clog2(N_PIPES)-1:0]  target_pipe,
    output logic [N_PIPES-1:0]          instr_write,
    output logic [N_PIPES-1:0]          reg_write,
    output logic [N_PIPES-1:0]          reg_commit,
    output logic [N_PIPES-1:0]          alloc_delay,
    output logic [N_PIPES-1:0]          pipe_reset,
    output logic [N_PIPES-1:0]          pipe_full_reset,
    input  logic [N_PIPES-1:0]          regfile_syncing,
    input  logic [N_PIPES-1:0]          pipe_resetting,
    output logic                        swap_req,
    input  logic                        swap_busy,
    output logic [$clog2(N_PIPES)-1:0]  active_pipe,
    output logic                        set_in_gain,
    output logic                        set_out_gain,
    output logic                        err_invalid,
    output logic                        err_timeout,
    output logic                        busy,
    output logic [3:0]                  state
);

    localparam int unsigned BLOCK_W  = $clog2(N_BLOCKS);
    localparam int unsigned PIPE_W   = $clog2(N_PIPES);
    localparam int unsigned DATA_NB  = DATA_W / 8;
    localparam int unsigned INSTR_NB = INSTR_W / 8;

    localparam logic [3:0] OP_WRITE_INSTR  = 4'd1;
    localparam logic [3:0] OP_WRITE_REG    = 4'd2;
    localparam logic [3:0] OP_COMMIT       = 4'd3;
    localparam logic [3:0] OP_ALLOC_DELAY  = 4'd4;
    localparam logic [3:0] OP_SWAP         = 4'd5;
    localparam logic [3:0] OP_RESET_PIPE   = 4'd6;
    localparam logic [3:0] OP_SET_IN_GAIN  = 4'd7;
    localparam logic [3:0] OP_SET_OUT_GAIN = 4'd8;

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StDecode    = 4'd1,
        StGetBlock  = 4'd2,
        StGetReg    = 4'd3,
        StGetData   = 4'd4,
        StGetInstr  = 4'd5,
        StGetDelay  = 4'd6,
        StExec      = 4'd7,
        StSwapWait  = 4'd8,
        StResetWait = 4'd9
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [PIPE_W-1:0]    target_pipe_q, target_pipe_d;
    logic [PIPE_W-1:0]    active_pipe_q, active_pipe_d;
    logic [BLOCK_W-1:0]   block_q, block_d;
    logic [REG_AW-1:0]    regaddr_q, regaddr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [31:0]          delay_q, delay_d;
    logic [7:0]           byte_cnt_q, byte_cnt_d;
    logic [31:0]          to_cnt_q, to_cnt_d;
    // Set for the first cycle spent in any state; the wait states ignore their
    // handshake inputs during that cycle.
    logic                 first_q, first_d;
    // Registered "WRITE_REG may proceed" flag, so reg_write never depends
    // combinationally on swap_busy / regfile_syncing.
    logic                 clear_q, clear_d;

    logic [3:0]           opcode;
    logic [3:0]           pipe_idx;
    logic                 is_get;
    logic                 accept;
    logic                 op_known;
    logic                 pipe_ok;
    logic                 swap_self;
    logic [N_PIPES-1:0]   tgt_onehot;
    logic [N_PIPES-1:0]   act_onehot;

    assign opcode     = cmd_q[7:4];
    assign pipe_idx   = cmd_q[3:0];
    assign is_get     = state_q inside {StGetBlock, StGetReg, StGetData, StGetInstr, StGetDelay};
    assign in_ready   = (state_q == StIdle) || is_get;
    assign accept     = in_valid && in_ready;
    assign op_known   = opcode inside {[OP_WRITE_INSTR:OP_SET_OUT_GAIN]};
    assign pipe_ok    = 32'(pipe_idx) < N_PIPES;
    assign swap_self  = (opcode == OP_SWAP) && (32'(pipe_idx) == 32'(active_pipe_q));
    assign tgt_onehot = N_PIPES'(1) << target_pipe_q;
    assign act_onehot = N_PIPES'(1) << active_pipe_q;

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        target_pipe_d   = target_pipe_q;
        active_pipe_d   = active_pipe_q;
        block_d         = block_q;
        regaddr_d       = regaddr_q;
        data_d          = data_q;
        instr_d         = instr_q;
        delay_d         = delay_q;
        byte_cnt_d      = byte_cnt_q;
        to_cnt_d        = to_cnt_q;
        clear_d         = !swap_busy && !regfile_syncing[target_pipe_q];
        instr_write     = '0;
        reg_write       = '0;
        reg_commit      = '0;
        alloc_delay     = '0;
        pipe_reset      = '0;
        pipe_full_reset = '0;
        swap_req        = 1'b0;
        set_in_gain     = 1'b0;
        set_out_gain    = 1'b0;
        err_invalid     = 1'b0;
        err_timeout     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cmd_d   = in_byte;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                byte_cnt_d = '0;
                to_cnt_d   = '0;
                if (!op_known || !pipe_ok || swap_self) begin
                    err_invalid = 1'b1;
                    state_d     = StIdle;
                end else begin
                    target_pipe_d = PIPE_W'(pipe_idx);
                    case (opcode)
                        OP_WRITE_INSTR, OP_WRITE_REG: state_d = StGetBlock;
                        OP_ALLOC_DELAY, OP_SET_IN_GAIN,
                        OP_SET_OUT_GAIN:              state_d = StGetData;
                        default:                      state_d = StExec;
                    endcase
                end
            end
            StGetBlock: begin
                if (accept) begin
                    block_d = in_byte[BLOCK_W-1:0];
                    state_d = (opcode == OP_WRITE_INSTR) ? StGetInstr : StGetReg;
                end
            end
            StGetReg: begin
                if (accept) begin
                    regaddr_d = in_byte[REG_AW-1:0];
                    state_d   = StGetData;
                end
            end
            StGetData: begin
                if (accept) begin
                    data_d = (data_q << 8) | DATA_W'(in_byte);
                    if (byte_cnt_q == 8'(DATA_NB - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = (opcode == OP_ALLOC_DELAY) ? StGetDelay : StExec;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            StGetInstr: begin
                if (accept) begin
                    instr_d = (instr_q << 8) | INSTR_W'(in_byte);
                    if (byte_cnt_q == 8'(INSTR_NB - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = StExec;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            StGetDelay: begin
                if (accept) begin
                    delay_d = {delay_q[23:0], in_byte};
                    if (byte_cnt_q == 8'd3) begin
                        byte_cnt_d = '0;
                        state_d    = StExec;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            StExec: begin
                state_d = StIdle;
                case (opcode)
                    OP_WRITE_INSTR:  instr_write = tgt_onehot;
                    OP_WRITE_REG: begin
                        if (clear_q) reg_write = tgt_onehot;
                        else         state_d   = StExec;
                    end
                    OP_COMMIT:       reg_commit  = tgt_onehot;
                    OP_ALLOC_DELAY:  alloc_delay = tgt_onehot;
                    OP_SWAP: begin
                        swap_req   = 1'b1;
                        reg_commit = tgt_onehot;
                        state_d    = StSwapWait;
                    end
                    OP_RESET_PIPE:   pipe_reset   = tgt_onehot;
                    OP_SET_IN_GAIN:  set_in_gain  = 1'b1;
                    OP_SET_OUT_GAIN: set_out_gain = 1'b1;
                    default: ;
                endcase
            end
            StSwapWait: begin
                if (!first_q && !swap_busy) begin
                    active_pipe_d   = target_pipe_q;
                    pipe_full_reset = act_onehot;
                    state_d         = StResetWait;
                end
            end
            StResetWait: begin
                if (!first_q && (pipe_resetting == '0)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Idle-cycle watchdog shared by all operand states; a timeout abandons the
        // command but keeps whatever operand fields were already shifted in.
        if (is_get) begin
            if (accept) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TIMEOUT - 1) begin
                err_timeout = 1'b1;
                state_d     = StIdle;
                to_cnt_d    = '0;
                byte_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + 32'd1;
            end
        end

        first_d = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cmd_q         <= '0;
            target_pipe_q <= '0;
            active_pipe_q <= '0;
            block_q       <= '0;
            regaddr_q     <= '0;
            data_q        <= '0;
            instr_q       <= '0;
            delay_q       <= '0;
            byte_cnt_q    <= '0;
            to_cnt_q      <= '0;
            first_q       <= 1'b0;
            clear_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            target_pipe_q <= target_pipe_d;
            active_pipe_q <= active_pipe_d;
            block_q       <= block_d;
            regaddr_q     <= regaddr_d;
            data_q        <= data_d;
            instr_q       <= instr_d;
            delay_q       <= delay_d;
            byte_cnt_q    <= byte_cnt_d;
            to_cnt_q      <= to_cnt_d;
            first_q       <= first_d;
            clear_q       <= clear_d;
        end
    end

    assign block_target = block_q;
    assign reg_target   = regaddr_q;
    assign data_out     = data_q;
    assign instr_out    = instr_q;
    assign delay_out    = delay_q;
    assign target_pipe  = target_pipe_q;
    assign active_pipe  = active_pipe_q;
    assign busy         = (state_q != StIdle);
    assign state        = state_q;

endmodule

// File: tb/tb_pipeline_cmd_ctrl.sv
// tb_pipeline_cmd_ctrl
//   Directed bench for pipeline_cmd_ctrl with N_PIPES=4 and TIMEOUT=8. Inputs change one
//   time unit after the rising edge; outputs are checked later in the same cycle.
module tb_pipeline_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  block_target;
    logic [3:0]  reg_target;
    logic [15:0] data_out;
    logic [31:0] instr_out;
    logic [31:0] delay_out;
    logic [1:0]  target_pipe;
    logic [3:0]  instr_write, reg_write, reg_commit, alloc_delay, pipe_reset, pipe_full_reset;
    logic [3:0]  regfile_syncing;
    logic [3:0]  pipe_resetting;
    logic        swap_req;
    logic        swap_busy;
    logic [1:0]  active_pipe;
    logic        set_in_gain, set_out_gain;
    logic        err_invalid, err_timeout;
    logic        busy;
    logic [3:0]  state;
    logic [26:0] strobes;

    int checks   = 0;
    int failures = 0;
    int rw_cnt   = 0;
    int iw_cnt   = 0;
    int ad_cnt   = 0;
    int snap;

    always #5 clk = ~clk;

    pipeline_cmd_ctrl #(
        .N_PIPES  (4),
        .N_BLOCKS (32),
        .DATA_W   (16),
        .INSTR_W  (32),
        .REG_AW   (4),
        .TIMEOUT  (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_byte         (in_byte),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .block_target    (block_target),
        .reg_target      (reg_target),
        .data_out        (data_out),
        .instr_out       (instr_out),
        .delay_out       (delay_out),
        .target_pipe     (target_pipe),
        .instr_write     (instr_write),
        .reg_write       (reg_write),
        .reg_commit      (reg_commit),
        .alloc_delay     (alloc_delay),
        .pipe_reset      (pipe_reset),
        .pipe_full_reset (pipe_full_reset),
        .regfile_syncing (regfile_syncing),
        .pipe_resetting  (pipe_resetting),
        .swap_req        (swap_req),
        .swap_busy       (swap_busy),
        .active_pipe     (active_pipe),
        .set_in_gain     (set_in_gain),
        .set_out_gain    (set_out_gain),
        .err_invalid     (err_invalid),
        .err_timeout     (err_timeout),
        .busy            (busy),
        .state           (state)
    );

    assign strobes = {instr_write, reg_write, reg_commit, alloc_delay, pipe_reset,
                      pipe_full_reset, swap_req, set_in_gain, set_out_gain};

    always @(posedge clk) begin
        if (reg_write != 4'd0)   rw_cnt <= rw_cnt + 1;
        if (instr_write != 4'd0) iw_cnt <= iw_cnt + 1;
        if (alloc_delay != 4'd0) ad_cnt <= ad_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for exactly one cycle, then drop in_valid.
    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        next();
        in_valid = 1'b0;
        #1;
    endtask

    logic [7:0] bad_cmds [4];

    initial begin
        bad_cmds = '{8'h90, 8'h24, 8'h0F, 8'h51};
        reset           = 1'b1;
        in_valid        = 1'b0;
        in_byte         = 8'h00;
        swap_busy       = 1'b0;
        regfile_syncing = 4'd0;
        pipe_resetting  = 4'd0;
        repeat (2) next();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_state", 64'(state), 64'd0);
        check("rst_active", 64'(active_pipe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_strobes", 64'(strobes), 64'd0);

        // WRITE_REG pipe 2, block 5, reg 3, data 0x1234
        push(8'h22);
        check("wr_decode_state", 64'(state), 64'd1);
        check("wr_decode_ready", 64'(in_ready), 64'd0);
        check("wr_decode_busy", 64'(busy), 64'd1);
        next();
        check("wr_getblock_state", 64'(state), 64'd2);
        push(8'h05);
        check("wr_getreg_state", 64'(state), 64'd3);
        push(8'h03);
        push(8'h12);
        push(8'h34);
        check("wr_exec_state", 64'(state), 64'd7);
        check("wr_exec_strobes", 64'(strobes), 64'h4 << 19);
        check("wr_block", 64'(block_target), 64'd5);
        check("wr_reg", 64'(reg_target), 64'd3);
        check("wr_data", 64'(data_out), 64'h1234);
        check("wr_target", 64'(target_pipe), 64'd2);
        next();
        check("wr_done_strobe", 64'(reg_write), 64'd0);
        check("wr_done_state", 64'(state), 64'd0);

        // SWAP to pipe 1 with swap_busy high for 5 cycles
        push(8'h51);
        check("sw_decode_err", 64'(err_invalid), 64'd0);
        next();
        swap_busy = 1'b1;
        #1;
        check("sw_req", 64'(swap_req), 64'd1);
        check("sw_commit", 64'(reg_commit), 64'h2);
        next();
        for (int i = 0; i < 4; i++) begin
            check("sw_wait_state", 64'(state), 64'd8);
            check("sw_wait_nofull", 64'(pipe_full_reset), 64'd0);
            next();
        end
        swap_busy      = 1'b0;
        pipe_resetting = 4'b0001;
        #1;
        check("sw_full_reset", 64'(pipe_full_reset), 64'h1);
        next();
        check("sw_rwait_state", 64'(state), 64'd9);
        check("sw_active", 64'(active_pipe), 64'd1);
        next();
        check("sw_rwait_hold", 64'(state), 64'd9);
        pipe_resetting = 4'd0;
        #1;
        next();
        check("sw_idle", 64'(state), 64'd0);
        push(8'h51);
        check("sw_repeat_err", 64'(err_invalid), 64'd1);
        check("sw_repeat_nostrobe", 64'(strobes), 64'd0);
        next();
        check("sw_repeat_idle", 64'(state), 64'd0);

        // WRITE_REG pipe 0 stalled by regfile_syncing[0] for 10 cycles
        snap = rw_cnt;
        regfile_syncing = 4'b0001;
        push(8'h20);
        next();
        push(8'h01);
        push(8'h02);
        push(8'hAB);
        push(8'hCD);
        for (int i = 0; i < 4; i++) begin
            check("sy_stall_state", 64'(state), 64'd7);
            check("sy_stall_strobe", 64'(reg_write), 64'd0);
            next();
        end
        regfile_syncing = 4'd0;
        #1;
        check("sy_drop_cycle", 64'(reg_write), 64'd0);
        next();
        check("sy_write", 64'(reg_write), 64'h1);
        next();
        check("sy_after", 64'(reg_write), 64'd0);
        check("sy_after_state", 64'(state), 64'd0);
        next();
        check("sy_count", 64'(rw_cnt - snap), 64'd1);

        // WRITE_INSTR pipe 0: block byte then silence -> timeout after 8 idle cycles
        snap = iw_cnt;
        push(8'h10);
        next();
        push(8'h02);
        for (int i = 1; i < 8; i++) begin
            check("to_wait_err", 64'(err_timeout), 64'd0);
            check("to_wait_state", 64'(state), 64'd5);
            next();
        end
        check("to_fire", 64'(err_timeout), 64'd1);
        check("to_no_instr", 64'(instr_write), 64'd0);
        next();
        check("to_idle", 64'(state), 64'd0);
        check("to_block_kept", 64'(block_target), 64'd2);
        push(8'h30);
        check("to_next_decode", 64'(state), 64'd1);
        next();
        check("to_next_commit", 64'(reg_commit), 64'h1);
        next();
        check("to_instr_count", 64'(iw_cnt - snap), 64'd0);

        // Invalid commands: unknown opcode, pipe out of range, opcode 0, swap to active
        for (int i = 0; i < 4; i++) begin
            push(bad_cmds[i]);
            check("inv_err", 64'(err_invalid), 64'd1);
            check("inv_nostrobe", 64'(strobes), 64'd0);
            next();
            check("inv_idle", 64'(state), 64'd0);
            check("inv_err_clear", 64'(err_invalid), 64'd0);
        end

        // RESET_PIPE pipe 3
        push(8'h63);
        next();
        check("rp_strobe", 64'(pipe_reset), 64'h8);
        check("rp_target", 64'(target_pipe), 64'd3);
        next();

        // SET_IN_GAIN / SET_OUT_GAIN
        push(8'h72);
        next();
        push(8'hA5);
        push(8'h5A);
        check("gi_strobe", 64'(set_in_gain), 64'd1);
        check("gi_data", 64'(data_out), 64'hA55A);
        next();
        push(8'h80);
        next();
        push(8'h00);
        push(8'h07);
        check("go_strobe", 64'(strobes), 64'd1);
        next();

        // WRITE_INSTR pipe 3, block byte 0x3F truncated to 5 bits
        push(8'h13);
        next();
        push(8'h3F);
        push(8'hDE);
        push(8'hAD);
        push(8'hBE);
        push(8'hEF);
        check("wi_strobe", 64'(instr_write), 64'h8);
        check("wi_block", 64'(block_target), 64'h1F);
        check("wi_instr", 64'(instr_out), 64'hDEADBEEF);
        next();

        // ALLOC_DELAY pipe 1
        push(8'h41);
        next();
        push(8'hBE);
        push(8'hEF);
        check("ad_getdelay", 64'(state), 64'd6);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        check("ad_strobe", 64'(alloc_delay), 64'h2);
        check("ad_delay", 64'(delay_out), 64'h01020304);
        check("ad_data", 64'(data_out), 64'hBEEF);
        next();

        // Reset in GET_DATA of ALLOC_DELAY, with a byte offered in the same cycle
        snap = ad_cnt;
        push(8'h40);
        next();
        push(8'h11);
        check("rs_getdata", 64'(state), 64'd4);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h22;
        next();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rs_state", 64'(state), 64'd0);
        check("rs_data", 64'(data_out), 64'd0);
        check("rs_delay", 64'(delay_out), 64'd0);
        check("rs_active", 64'(active_pipe), 64'd0);
        check("rs_strobes", 64'(strobes), 64'd0);
        push(8'h30);
        next();
        check("rs_commit", 64'(reg_commit), 64'h1);
        next();
        check("rs_no_alloc", 64'(ad_cnt - snap), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
